ahb_slave_if: RTL and testbench

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_xfer_chk.sv | 14 +
 rtl/ahb_slave_if.sv | 69 ++++++
 tb/tb_ahb_slave_if.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/response encodings and slave FSM states shared with the SRAM side.
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;
    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;
endpackage

// File: rtl/ahb_xfer_chk.sv
// ahb_xfer_chk: flags oversize or misaligned AHB transfers.
module ahb_xfer_chk
    import ahb_pkg::*;
#(
    parameter logic [2:0] MAX_HSIZE = HSIZE_WORD
) (
    input  logic [2:0] hsize,
    input  logic [1:0] haddr,
    output logic       illegal
);
    assign illegal = (hsize > MAX_HSIZE)
                   | ((hsize == HSIZE_HALF) & haddr[0])
                   | ((hsize == HSIZE_WORD) & (|haddr));
endmodule

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB slave front end registering data-phase control for an SRAM controller.
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic                      hready,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    output logic                      hsel_reg,
    output logic                      hwrite_reg,
    output logic [2:0]                hsize_reg,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_reg,
    output logic                      hready_resp,
    output logic [1:0]                hresp
);
    localparam logic [2:0] MAX_HSIZE = 3'($clog2(AHB_DATA_WIDTH / 8));
    state_e state, state_nxt;
    logic valid, sample, illegal, stall;
    ahb_xfer_chk #(.MAX_HSIZE(MAX_HSIZE)) u_chk (
        .hsize  (hsize),
        .haddr  (haddr[1:0]),
        .illegal(illegal)
    );
    assign valid  = hsel & hready & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    // ERR1 and WAIT hold hready low, so nothing is ever taken there
    assign sample = valid & (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
    // a read right behind a write needs one cycle for the SRAM write to retire
    assign stall  = (state == ST_DATA) & hwrite_reg & ~hwrite;
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_WAIT: state_nxt = ST_DATA;
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (sample && illegal) state_nxt = ST_ERR1;
                else if (sample && stall) state_nxt = ST_WAIT;
                else if (sample) state_nxt = ST_DATA;
            end
        endcase
    end
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state       <= ST_IDLE;
            hsel_reg    <= 1'b0;
            hwrite_reg  <= 1'b0;
            hsize_reg   <= 3'b000;
            haddr_reg   <= '0;
            hready_resp <= 1'b1;
            hresp       <= HRESP_OKAY;
        end else begin
            state       <= state_nxt;
            hsel_reg    <= state_nxt == ST_DATA;
            hready_resp <= !(state_nxt == ST_WAIT || state_nxt == ST_ERR1);
            hresp       <= (state_nxt == ST_ERR1 || state_nxt == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
            if (sample && !illegal) begin
                hwrite_reg <= hwrite;
                hsize_reg  <= hsize;
                haddr_reg  <= haddr;
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_if.sv
// tb_ahb_slave_if: directed AHB transfers checked against a behavioural slave model every cycle.
module tb_ahb_slave_if;
    logic        hclk = 1'b0;
    logic        hreset, hsel, hready, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic        hsel_reg, hwrite_reg, hready_resp;
    logic [2:0]  hsize_reg;
    logic [31:0] haddr_reg;
    logic [1:0]  hresp;
    int n_chk = 0;
    int n_fail = 0;

    ahb_slave_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hsel_reg(hsel_reg),
        .hwrite_reg(hwrite_reg), .hsize_reg(hsize_reg), .haddr_reg(haddr_reg),
        .hready_resp(hready_resp), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    // model: outstanding error cycles, a pending read stall, and the current data phase
    logic        m_sel, m_wr, m_rdy, in_wait;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [1:0]  m_resp;
    int          err_left;
    logic        take, bad, stall;

    function automatic logic bad_xfer(input logic [2:0] z, input logic [31:0] a);
        if (z > 3'd2) return 1'b1;
        return (a & ((32'd1 << z) - 32'd1)) != 32'd0;
    endfunction

    assign take  = hsel && hready && htrans[1];
    assign bad   = bad_xfer(hsize, haddr);
    assign stall = m_sel && m_wr && !hwrite;

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            m_sel <= 0; m_wr <= 0; m_size <= 0; m_addr <= 0; m_rdy <= 1; m_resp <= 0;
            err_left <= 0; in_wait <= 0;
        end else if (err_left == 2) begin
            err_left <= 1; m_sel <= 0; m_rdy <= 1; m_resp <= 1;
        end else if (in_wait) begin
            in_wait <= 0; m_sel <= 1; m_rdy <= 1; m_resp <= 0;
        end else if (take && bad) begin
            err_left <= 2; m_sel <= 0; m_rdy <= 0; m_resp <= 1;
        end else if (take) begin
            err_left <= 0; in_wait <= stall; m_sel <= !stall; m_rdy <= !stall; m_resp <= 0;
            m_wr <= hwrite; m_size <= hsize; m_addr <= haddr;
        end else begin
            err_left <= 0; m_sel <= 0; m_rdy <= 1; m_resp <= 0;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge hclk) begin
        chk("cmp_hsel_reg", 32'(hsel_reg), 32'(m_sel));
        chk("cmp_hwrite_reg", 32'(hwrite_reg), 32'(m_wr));
        chk("cmp_hsize_reg", 32'(hsize_reg), 32'(m_size));
        chk("cmp_haddr_reg", haddr_reg, m_addr);
        chk("cmp_hready_resp", 32'(hready_resp), 32'(m_rdy));
        chk("cmp_hresp", 32'(hresp), 32'(m_resp));
    end

    task automatic cyc(input int s, input int r, input int t, input int w, input int z,
                       input logic [31:0] a);
        hsel = s[0]; hready = r[0]; htrans = t[1:0]; hwrite = w[0]; hsize = z[2:0]; haddr = a;
        @(posedge hclk);
        @(negedge hclk);
    endtask

    initial begin
        hreset = 0; hsel = 0; hready = 1; htrans = 0; hwrite = 0; hsize = 0; haddr = 0;
        #1 hreset = 1;
        @(negedge hclk);
        chk("rst_rdy", 32'(hready_resp), 1);
        chk("rst_sel", 32'(hsel_reg), 0);
        chk("rst_addr", haddr_reg, 0);
        hreset = 0;
        cyc(1, 1, 2, 1, 2, 32'h10);
        chk("w10_sel", 32'(hsel_reg), 1);
        chk("w10_addr", haddr_reg, 32'h10);
        chk("w10_wr", 32'(hwrite_reg), 1);
        chk("w10_resp", 32'(hresp), 0);
        cyc(1, 1, 0, 0, 0, 32'h0);
        chk("idle_sel", 32'(hsel_reg), 0);
        chk("idle_addr", haddr_reg, 32'h10);
        cyc(1, 1, 2, 1, 2, 32'h20);
        cyc(1, 1, 2, 0, 2, 32'h20);
        chk("wait_rdy", 32'(hready_resp), 0);
        chk("wait_sel", 32'(hsel_reg), 0);
        chk("wait_addr", haddr_reg, 32'h20);
        cyc(1, 0, 0, 0, 0, 32'h0);
        chk("rd20_sel", 32'(hsel_reg), 1);
        chk("rd20_rdy", 32'(hready_resp), 1);
        chk("rd20_wr", 32'(hwrite_reg), 0);
        cyc(1, 1, 2, 0, 2, 32'h24);
        chk("rd24_rdy", 32'(hready_resp), 1);
        chk("rd24_addr", haddr_reg, 32'h24);
        cyc(1, 1, 3, 1, 1, 32'h26);
        chk("wh26_sel", 32'(hsel_reg), 1);
        chk("wh26_size", 32'(hsize_reg), 1);
        cyc(1, 1, 0, 0, 0, 32'h0);
        cyc(1, 1, 2, 1, 2, 32'h2);
        chk("err1_rdy", 32'(hready_resp), 0);
        chk("err1_resp", 32'(hresp), 1);
        chk("err1_addr", haddr_reg, 32'h26);
        cyc(1, 0, 0, 0, 0, 32'h0);
        chk("err2_rdy", 32'(hready_resp), 1);
        chk("err2_resp", 32'(hresp), 1);
        chk("err2_sel", 32'(hsel_reg), 0);
        cyc(1, 1, 0, 0, 0, 32'h0);
        chk("post_err_resp", 32'(hresp), 0);
        cyc(1, 1, 2, 0, 3, 32'h0);
        chk("sz3_resp", 32'(hresp), 1);
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 2, 0, 0, 32'h3);
        chk("b3_sel", 32'(hsel_reg), 1);
        chk("b3_addr", haddr_reg, 32'h3);
        chk("b3_resp", 32'(hresp), 0);
        cyc(1, 1, 2, 0, 1, 32'h5);
        chk("h5_rdy", 32'(hready_resp), 0);
        chk("h5_addr", haddr_reg, 32'h3);
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(1, 1, 0, 0, 0, 32'h0);
        cyc(1, 1, 1, 1, 2, 32'h40);
        chk("busy_sel", 32'(hsel_reg), 0);
        cyc(0, 1, 2, 1, 2, 32'h44);
        chk("nosel_addr", haddr_reg, 32'h3);
        cyc(1, 0, 2, 1, 2, 32'h48);
        chk("nordy_addr", haddr_reg, 32'h3);
        chk("nordy_resp", 32'(hresp), 0);
        cyc(1, 1, 2, 1, 2, 32'h80);
        cyc(1, 1, 2, 0, 2, 32'h84);
        chk("w2_rdy", 32'(hready_resp), 0);
        #2 hreset = 1;
        #1;
        chk("arst_rdy", 32'(hready_resp), 1);
        chk("arst_addr", haddr_reg, 0);
        chk("arst_wr", 32'(hwrite_reg), 0);
        @(negedge hclk);
        hreset = 0;
        cyc(1, 1, 2, 0, 2, 32'h8);
        chk("r8_sel", 32'(hsel_reg), 1);
        chk("r8_addr", haddr_reg, 32'h8);
        cyc(1, 1, 2, 1, 2, 32'h1);
        chk("e1_resp", 32'(hresp), 1);
        #2 hreset = 1;
        #1;
        chk("arst_e_resp", 32'(hresp), 0);
        chk("arst_e_rdy", 32'(hready_resp), 1);
        @(negedge hclk);
        hreset = 0;
        cyc(1, 1, 0, 0, 0, 32'h0);
        chk("post_rst_resp", 32'(hresp), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
